// File: rtl/blake_pkg.sv
// Shared BLAKE-256 constants for the message scheduler: sigma permutation table,
// the sixteen c constants and the scheduler state type.
package blake_pkg;

  typedef enum logic {StIdle, StStream} state_e;

  localparam int unsigned NumRows = 10;

  localparam logic [3:0] Sigma [NumRows][16] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
      4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,
      4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3},
    '{4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13,
      4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4},
    '{4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14,
      4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8},
    '{4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15,
      4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13},
    '{4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,
      4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9},
    '{4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10,
      4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11},
    '{4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,
      4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10},
    '{4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,
      4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5},
    '{4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,
      4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0}
  };

  localparam logic [31:0] Cst [16] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C5DD7, 32'h3F84D5B5, 32'hB5470917
  };

  // Rounds never exceed 13, so a single conditional subtract gives round mod 10.
  function automatic logic [3:0] round_to_row(input logic [3:0] round);
    return (round >= 4'd10) ? round - 4'd10 : round;
  endfunction

endpackage

// File: rtl/blake_msg_sched_if.sv
// Load and beat handshakes of the BLAKE message scheduler; slave is the scheduler's view.
interface blake_msg_sched_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_msg;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  msg_i;
  logic [31:0]  msg_ip;
  logic [3:0]   round_idx;
  logic [2:0]   g_idx;
  logic         last;

  modport master (
    output in_valid, in_msg, flush, out_ready,
    input  in_ready, out_valid, msg_i, msg_ip, round_idx, g_idx, last
  );

  modport slave (
    input  in_valid, in_msg, flush, out_ready,
    output in_ready, out_valid, msg_i, msg_ip, round_idx, g_idx, last
  );
endinterface

// File: rtl/blake_sigma_lookup.sv
// Maps a sigma row and G index to the two message word indices that G consumes.
module blake_sigma_lookup
  import blake_pkg::*;
(
  input  logic [3:0] i_row,
  input  logic [2:0] i_g,
  output logic [3:0] o_idx_a,
  output logic [3:0] o_idx_b
);

  logic [3:0] w_row;

  always_comb begin
    w_row   = (i_row < 4'(NumRows)) ? i_row : 4'd0;
    o_idx_a = Sigma[w_row][{i_g, 1'b0}];
    o_idx_b = Sigma[w_row][{i_g, 1'b1}];
  end

endmodule

// File: rtl/blake_msg_sched.sv
// Streams the BLAKE-256 per-G message/constant XOR pairs of one block, ROUNDS*8 beats,
// to the pipelined G stage over a valid/ready handshake.
module blake_msg_sched
  import blake_pkg::*;
#(
  parameter int unsigned ROUNDS = 8
) (
  input logic               clk,
  input logic               rst,
  blake_msg_sched_if.slave  bus
);

  localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_m [16];
  logic [31:0] w_word [16];
  logic [3:0]  r_round, w_round_nxt;
  logic [2:0]  r_g, w_g_nxt;
  logic        r_last, w_last_nxt;
  logic [31:0] r_msg_i, r_msg_ip, w_msg_i_nxt, w_msg_ip_nxt;
  logic        w_load, w_update, w_clear;
  logic [3:0]  w_row, w_idx_a, w_idx_b;

  always_comb begin
    w_load      = (r_state == StIdle) && bus.in_valid;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_g_nxt     = r_g;
    w_update    = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_state_nxt = StStream;
          w_round_nxt = '0;
          w_g_nxt     = '0;
          w_update    = 1'b1;
        end
      end
      StStream: begin
        if (bus.out_ready) begin
          if (r_last) begin
            w_state_nxt = StIdle;
            w_clear     = 1'b1;
          end else begin
            w_g_nxt     = r_g + 3'd1;
            w_round_nxt = (r_g == 3'd7) ? r_round + 4'd1 : r_round;
            w_update    = 1'b1;
          end
        end
      end
    endcase
    // Flush wins over both a load and a beat acceptance.
    if (bus.flush) begin
      w_state_nxt = StIdle;
      w_update    = 1'b0;
      w_clear     = 1'b1;
    end
    if (w_clear) begin
      w_round_nxt = '0;
      w_g_nxt     = '0;
    end
  end

  assign w_row = round_to_row(w_round_nxt);

  blake_sigma_lookup u_sigma (
    .i_row   (w_row),
    .i_g     (w_g_nxt),
    .o_idx_a (w_idx_a),
    .o_idx_b (w_idx_b)
  );

  // The first beat is formed from in_msg directly so it can appear the cycle after the load.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_word[k] = w_load ? bus.in_msg[511 - 32*k -: 32] : r_m[k];
    end
    w_msg_i_nxt  = r_msg_i;
    w_msg_ip_nxt = r_msg_ip;
    w_last_nxt   = r_last;
    if (w_clear) begin
      w_msg_i_nxt  = '0;
      w_msg_ip_nxt = '0;
      w_last_nxt   = 1'b0;
    end else if (w_update) begin
      w_msg_i_nxt  = w_word[w_idx_a] ^ Cst[w_idx_b];
      w_msg_ip_nxt = w_word[w_idx_b] ^ Cst[w_idx_a];
      w_last_nxt   = (w_round_nxt == LastRound) && (w_g_nxt == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (w_load && !bus.flush) begin
      for (int k = 0; k < 16; k++) begin
        r_m[k] <= bus.in_msg[511 - 32*k -: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_round  <= '0;
      r_g      <= '0;
      r_last   <= 1'b0;
      r_msg_i  <= '0;
      r_msg_ip <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_round  <= w_round_nxt;
      r_g      <= w_g_nxt;
      r_last   <= w_last_nxt;
      r_msg_i  <= w_msg_i_nxt;
      r_msg_ip <= w_msg_ip_nxt;
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StStream);
  assign bus.msg_i     = r_msg_i;
  assign bus.msg_ip    = r_msg_ip;
  assign bus.round_idx = r_round;
  assign bus.g_idx     = r_g;
  assign bus.last      = r_last;

endmodule

// File: tb/tb_blake_msg_sched.sv
// Scoreboard bench: one scheduler with 8 rounds (full scenario set) and one with 14 rounds.
module tb_blake_msg_sched;

  localparam int SIG [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}
  };
  localparam logic [31:0] CST [16] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C5DD7, 32'h3F84D5B5, 32'hB5470917
  };

  typedef struct packed {
    logic [31:0] mi;
    logic [31:0] mip;
    logic [3:0]  r;
    logic [2:0]  g;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  blake_msg_sched_if bus_a ();
  blake_msg_sched_if bus_b ();

  blake_msg_sched #(.ROUNDS(8)) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  blake_msg_sched #(.ROUNDS(14)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int    n_vec = 0;
  int    n_err = 0;
  int    beats_a = 0;
  bit    done_b = 1'b0;
  beat_t q_a[$];
  beat_t q_b[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat b of a block, straight from the BLAKE definition of the G inputs.
  function automatic beat_t model_beat(input logic [511:0] msg, input int rounds, input int b);
    int    r, g, a, c;
    beat_t e;
    r = b / 8;
    g = b % 8;
    a = SIG[r % 10][2*g];
    c = SIG[r % 10][2*g + 1];
    e.mi  = msg[511 - 32*a -: 32] ^ CST[c];
    e.mip = msg[511 - 32*c -: 32] ^ CST[a];
    e.r   = 4'(r);
    e.g   = 3'(g);
    e.l   = (b == rounds*8 - 1);
    return e;
  endfunction

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[511 - 32*k -: 32] = $urandom;
    return m;
  endfunction

  // Monitors: pop and compare on every accepted beat, check holding while stalled.
  initial begin
    beat_t cur, held;
    bit    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a || !bus_a.out_valid) begin
        stall = 1'b0;
      end else begin
        cur = {bus_a.msg_i, bus_a.msg_ip, bus_a.round_idx, bus_a.g_idx, bus_a.last};
        if (stall) chk("stall_hold_a", 72'(cur), 72'(held));
        if (bus_a.out_ready && !bus_a.flush) begin
          if (q_a.size() == 0) chk("extra_beat_a", 72'(q_a.size()), 72'd1);
          else chk("beat_a", 72'(cur), 72'(q_a.pop_front()));
          beats_a++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = cur;
        end
      end
    end
  end

  initial begin
    beat_t cur, held;
    bit    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b || !bus_b.out_valid) begin
        stall = 1'b0;
      end else begin
        cur = {bus_b.msg_i, bus_b.msg_ip, bus_b.round_idx, bus_b.g_idx, bus_b.last};
        if (stall) chk("stall_hold_b", 72'(cur), 72'(held));
        if (bus_b.out_ready && !bus_b.flush) begin
          if (q_b.size() == 0) chk("extra_beat_b", 72'(q_b.size()), 72'd1);
          else chk("beat_b", 72'(cur), 72'(q_b.pop_front()));
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = cur;
        end
      end
    end
  end

  task automatic load_a(input logic [511:0] msg);
    int n = 0;
    @(posedge clk); #1;
    while (!bus_a.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_ready_a", 72'(bus_a.in_ready), 72'd1);
    bus_a.in_valid = 1'b1;
    bus_a.in_msg   = msg;
    for (int b = 0; b < 64; b++) q_a.push_back(model_beat(msg, 8, b));
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic drain_a(input bit rand_ready);
    int n = 0;
    while ((q_a.size() != 0 || !bus_a.in_ready) && n < 3000) begin
      if (rand_ready) bus_a.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      n++;
    end
    bus_a.out_ready = 1'b1;
    chk("drain_a", 72'({q_a.size() != 0, bus_a.in_ready}), 72'b01);
  endtask

  // Back-to-back block with out_ready held: 64 gapless beats then idle.
  task automatic full_block_a(input logic [511:0] msg, input bit lit);
    int gaps = 0;
    bus_a.out_ready = 1'b1;
    load_a(msg);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!bus_a.out_valid) gaps++;
      if (lit && k == 0)
        chk("beat0_lit", 72'({bus_a.msg_i, bus_a.msg_ip}), 72'h85A308D3_243F6A88);
      if (lit && k == 8)
        chk("beat8_lit", 72'({bus_a.msg_i, bus_a.msg_ip, bus_a.round_idx, bus_a.g_idx}),
            72'({64'hBE5466CF_3F84D5B5, 4'd1, 3'd0}));
    end
    chk("gapless_64", 72'(gaps), 72'd0);
    @(negedge clk);
    chk("idle_after_last", 72'({bus_a.in_ready, bus_a.out_valid}), 72'b10);
  endtask

  initial begin
    logic [511:0] m;
    int           n, start;
    #400_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [511:0] m;
    int           n, start;
    bus_a.in_valid = 1'b0; bus_a.in_msg = '0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
    #1 rst_a = 1'b1;
    #11;
    chk("rst_ready_valid", 72'({bus_a.in_ready, bus_a.out_valid, bus_a.last}), 72'b100);
    chk("rst_idx", 72'({bus_a.round_idx, bus_a.g_idx}), 72'd0);
    chk("rst_msg", 72'({bus_a.msg_i, bus_a.msg_ip}), 72'd0);
    #10 rst_a = 1'b0;

    full_block_a('0, 1'b1);
    for (int k = 0; k < 16; k++) m[511 - 32*k -: 32] = k;
    full_block_a(m, 1'b0);

    for (int i = 0; i < 3; i++) begin
      load_a(rand_msg());
      drain_a(1'b1);
    end

    // Flush at beat 20 alongside a load request.
    load_a(rand_msg());
    start = beats_a - 1;
    n = 0;
    while (beats_a - start < 20 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_beat20", 72'(beats_a - start), 72'd20);
    bus_a.flush = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_msg = rand_msg();
    @(posedge clk); #1;
    bus_a.flush = 1'b0;
    bus_a.in_valid = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk("flush_idle", 72'({bus_a.in_ready, bus_a.out_valid}), 72'b10);
    @(negedge clk);
    chk("flush_no_load", 72'({bus_a.in_ready, bus_a.out_valid}), 72'b10);
    load_a(rand_msg());
    drain_a(1'b0);

    // Asynchronous reset in the middle of a block.
    load_a(rand_msg());
    repeat (10) @(posedge clk);
    #3 rst_a = 1'b1;
    #1;
    chk("async_rst", 72'({bus_a.in_ready, bus_a.out_valid, bus_a.round_idx, bus_a.g_idx}),
        72'({2'b10, 4'd0, 3'd0}));
    q_a.delete();
    #10 rst_a = 1'b0;
    load_a(rand_msg());
    drain_a(1'b1);

    n = 0;
    while (!done_b && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("done_b", 72'(done_b), 72'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Fourteen rounds: rounds 10..13 must wrap back onto sigma rows 0..3.
  initial begin
    logic [511:0] m;
    int           n;
    bus_b.in_valid = 1'b0; bus_b.in_msg = '0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;
    #1 rst_b = 1'b1;
    #21 rst_b = 1'b0;
    for (int blk = 0; blk < 2; blk++) begin
      m = rand_msg();
      @(posedge clk); #1;
      bus_b.in_valid = 1'b1;
      bus_b.in_msg   = m;
      for (int b = 0; b < 112; b++) q_b.push_back(model_beat(m, 14, b));
      @(posedge clk); #1;
      bus_b.in_valid = 1'b0;
      n = 0;
      while ((q_b.size() != 0 || !bus_b.in_ready) && n < 3000) begin
        if (blk == 1) bus_b.out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
        n++;
      end
      bus_b.out_ready = 1'b1;
      chk("drain_b", 72'({q_b.size() != 0, bus_b.in_ready}), 72'b01);
    end
    done_b = 1'b1;
  end

endmodule

// File: doc/blake_msg_sched.md
BLAKE_MSG_SCHED -- requirements
Module: blake_msg_sched

Interface
REQ-001 Parameter: ROUNDS, default 8, number of BLAKE-256 rounds streamed per block (legal 1..14).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  message block on in_msg is valid.
REQ-005 Port: in_ready  output  1  block accepted on a cycle where in_valid and in_ready are both high.
REQ-006 Port: in_msg  input  512  message words m0..m15, with m0 in bits [511:480] and m15 in bits [31:0].
REQ-007 Port: flush  input  1  synchronous abort of the current block.
REQ-008 Port: out_valid  output  1  msg_i/msg_ip beat is valid.
REQ-009 Port: out_ready  input  1  consumer takes the beat when out_valid and out_ready are both high.
REQ-010 Port: msg_i  output  32  m[s(2g)] ^ c[s(2g+1)] for the current round and G index.
REQ-011 Port: msg_ip  output  32  m[s(2g+1)] ^ c[s(2g)] for the current round and G index.
REQ-012 Port: round_idx  output  4  round number of the current beat.
REQ-013 Port: g_idx  output  3  G index of the current beat: 0-3 columns, 4-7 diagonals.
REQ-014 Port: last  output  1  high on the final beat of a block.

Function
REQ-015 States SHALL be IDLE and STREAM.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 In STREAM, in_ready SHALL be 0.
REQ-018 A load handshake in IDLE SHALL register all 16 words, clear round_idx and g_idx to 0, and enter STREAM; out_valid SHALL rise on the next cycle.
REQ-019 s SHALL be the BLAKE sigma row sigma[round_idx mod 10]; c SHALL be the 16 BLAKE-256 constants c0=243F6A88 .. c15=B5470917.
REQ-020 msg_i, msg_ip, round_idx, g_idx and last SHALL be driven from registers, with no combinational path from out_ready.
REQ-021 While out_valid is high and out_ready is low, all outputs SHALL hold stable.
REQ-022 On each accepted beat, g_idx SHALL increment; when g_idx wraps from 7 to 0, round_idx SHALL increment.
REQ-023 Beats per block SHALL be ROUNDS*8, emitted in order round 0 G0..G7, round 1 G0..G7, and so on.
REQ-024 last SHALL be 1 exactly when round_idx = ROUNDS-1 and g_idx = 7.
REQ-025 Acceptance of the last beat SHALL return the block to IDLE with out_valid 0 on the next cycle; in_ready SHALL then be 1, so the minimum gap between blocks is one cycle.
REQ-026 The outputs SHALL sustain one beat per clock while out_ready is held high (no bubbles inside a block).
REQ-027 flush SHALL force IDLE on the next edge from either state and discard the current block.
REQ-028 flush SHALL take priority over a simultaneous load handshake and over a simultaneous beat acceptance.
REQ-029 Message words SHALL NOT change during STREAM; in_msg is ignored outside a load handshake.
REQ-030 XOR SHALL be 32-bit bitwise; no additions are performed in this block.

Reset
REQ-031 rst SHALL force the following values asynchronously: state IDLE, out_valid 0, in_ready 1, last 0, round_idx 0, g_idx 0, msg_i 0, msg_ip 0.
REQ-032 The message registers need no reset.
REQ-033 rst asserted mid-block SHALL abandon the block.
REQ-034 After rst deasserts, the first block SHALL stream from round 0 G0.

Structure
REQ-035 A shared package blake_pkg SHALL hold the sigma table (10x16 of 4-bit entries), the c constant array (16x32), and the state enum.
REQ-036 The consumer is the pipelined G stage, which SHALL be fed msg_i/msg_ip directly.
REQ-037 One sub-module is natural: blake_sigma_lookup, combinational, mapping (round mod 10, g) to two word indices.
REQ-038 The sub-module outputs SHALL be registered in blake_msg_sched.

Verification
REQ-039 Load m=0, out_ready=1 -> beat 0: msg_i=85A308D3, msg_ip=243F6A88, round_idx 0, g_idx 0.
REQ-040 Same block -> beat 8: round 1 G0, msg_i=BE5466CF (c10), msg_ip=3F84D5B5 (c14).
REQ-041 Load m_k=k, ROUNDS=8, out_ready=1 -> exactly 64 consecutive beats, last only on beat 63, in_ready=1 one cycle after it, and every beat matches the golden model.
REQ-042 Toggle out_ready randomly -> no beat is dropped or duplicated and outputs are stable while stalled.
REQ-043 Assert flush at beat 20 together with in_valid -> IDLE next cycle, no load taken, a new block then streams from round 0 G0.
REQ-044 Assert rst asynchronously mid-block -> out_valid=0 and in_ready=1 immediately; ROUNDS=14 -> round 10 uses sigma row 0.
